a0_trace_buffer: RTL and testbench

- Downstream consumer of the CPU's a0 result register output.
- Detects every change of a0 and pushes the new value into a small FIFO.
- Drains to a display/host over a valid/ready handshake, so a slow sink sees every a0 value the program produces rather than only the latest.
- Counts drops on overflow.

---
 rtl/a0_trace_pkg.sv | 15 +
 rtl/a0_trace_buffer_fifo.sv | 74 +++++++
 rtl/a0_trace_buffer.sv | 91 +++++++++
 tb/tb_a0_trace_buffer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/a0_trace_pkg.sv
// Shared defaults and helpers for the a0 trace buffer.
package a0_trace_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDepth = 16;
  localparam int unsigned DefaultCntW  = 8;

  // One extra pointer bit distinguishes full from empty when the index bits match.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef logic [DefaultWidth-1:0] trace_entry_t;

endpackage

// File: rtl/a0_trace_buffer_fifo.sv
// Generic synchronous show-ahead FIFO. The head is held in a register so it
// reads as 0 after reset and keeps its last value when the FIFO drains empty.
module trace_fifo
  import a0_trace_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PtrW  = ptr_width(DEPTH);
  localparam int unsigned AddrW = PtrW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]  wr_ptr_d, rd_ptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             push_ok, pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A pop frees a slot on the same edge, so a full FIFO can push and pop together.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign wr_ptr_d = wr_ptr_q + {{(PtrW-1){1'b0}}, push_ok};
  assign rd_ptr_d = rd_ptr_q + {{(PtrW-1){1'b0}}, pop_ok};
  assign rd_data  = rd_data_q;

  // Next head value: following entry, the incoming write if it lands at the head, else hold.
  always_comb begin
    rd_data_d = rd_data_q;
    if (pop_ok) begin
      if (rd_ptr_d == wr_ptr_q) begin
        if (push_ok) rd_data_d = wr_data;
      end else begin
        rd_data_d = mem_q[rd_ptr_d[AddrW-1:0]];
      end
    end else if (empty && push_ok) begin
      rd_data_d = wr_data;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data;
  end

  // Pointers and registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/a0_trace_buffer.sv
// Captures every change of the CPU a0 register into a FIFO drained over
// valid/ready, counting captures lost to overflow.
module a0_trace_buffer
  import a0_trace_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth,  // power of two, >= 2
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       a0_in,
  input  logic                   capture_en,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  input  logic                   clr_status
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [WIDTH-1:0] prev_a0_q;
  logic             first_q;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             capture_req, pop, drop;
  logic             fifo_full, fifo_empty;

  // first_q forces the first post-reset value in, even when it equals the reset value of prev_a0.
  assign capture_req = capture_en & (first_q | (a0_in != prev_a0_q));
  assign out_valid   = ~fifo_empty;
  assign pop         = out_valid & out_ready;
  assign drop        = capture_req & fifo_full & ~pop;
  assign overflow    = overflow_q;
  assign drop_count  = drop_count_q;

  trace_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (capture_req),
    .pop     (out_ready),
    .wr_data (a0_in),
    .rd_data (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  // Change tracking runs regardless of capture_en so re-enabling does not capture a stale value.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a0_q <= '0;
      first_q   <= 1'b1;
    end else begin
      prev_a0_q <= a0_in;
      first_q   <= 1'b0;
    end
  end

  // Drop status; a drop in the same cycle as a clear wins and counts as the first drop.
  always_comb begin
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overflow_d   = 1'b1;
      if (clr_status) drop_count_d = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (drop_count_q != CntMax) drop_count_d = drop_count_q + 1'b1;
    end else if (clr_status) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_a0_trace_buffer.sv
// Scoreboard bench: stimulus queues expected captures, a negedge monitor
// compares every accepted head against the queue.
module tb_a0_trace_buffer;
  import a0_trace_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a0_in;
  logic             capture_en;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       level;
  logic             overflow;
  logic [CNT_W-1:0] drop_count;
  logic             clr_status;

  int errors = 0;
  int checks = 0;
  trace_entry_t exp_q[$];

  always #5 clk = ~clk;

  a0_trace_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .a0_in      (a0_in),
    .capture_en (capture_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clr_status (clr_status)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every handshake must match the oldest expected capture.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", out_data, 32'hdead_beef);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [WIDTH-1:0] v, input bit expect_push);
    a0_in = v;
    if (expect_push) exp_q.push_back(v);
    tick();
  endtask

  // Drain with a bounded cycle budget, holding a0 steady.
  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 64 && (exp_q.size() != 0 || out_valid); i++) tick();
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_valid_low"}, out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; a0_in = '0; capture_en = 1'b0; out_ready = 1'b0; clr_status = 1'b0;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_out_data", out_data, 0);

    // 1: first value after reset is captured even though it is 0.
    rst = 1'b0; capture_en = 1'b1; out_ready = 1'b1;
    step(0, 1);
    check("t1_level", level, 1);
    check("t1_valid", out_valid, 1);
    step(0, 0);
    check("t1_level_after", level, 0);
    step(0, 0);
    check("t1_valid_after", out_valid, 0);

    // 2: repeated values captured once each.
    step(5, 1); check("t2_lvl_a", level <= 1, 1);
    step(5, 0); check("t2_lvl_b", level <= 1, 1);
    step(7, 1); check("t2_lvl_c", level <= 1, 1);
    step(7, 0); check("t2_lvl_d", level <= 1, 1);
    step(9, 1); check("t2_lvl_e", level <= 1, 1);
    drain("t2");

    // 3: 17 values into a 16-deep FIFO with the sink stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) step(100 + i, i < 16);
    check("t3_level", level, 16);
    check("t3_overflow", overflow, 1);
    check("t3_drop_count", drop_count, 1);

    // 4: push and pop together while full.
    out_ready = 1'b1;
    step(200, 1);
    out_ready = 1'b0;
    check("t4_level", level, 16);
    check("t4_drop_count", drop_count, 1);
    drain("t4");

    // 5: saturation and clear/drop collision.
    out_ready = 1'b0;
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    check("t5_clr_overflow", overflow, 0);
    check("t5_clr_count", drop_count, 0);
    for (int i = 0; i < 16; i++) step(1000 + i, 1);
    for (int i = 0; i < 255; i++) step(2000 + i, 0);
    check("t5_count_255", drop_count, 255);
    step(3000, 0);
    check("t5_count_sat", drop_count, 255);
    check("t5_overflow", overflow, 1);
    clr_status = 1'b1;
    step(3001, 0);
    clr_status = 1'b0;
    check("t5_clr_drop_ovf", overflow, 1);
    check("t5_clr_drop_cnt", drop_count, 1);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    check("t5_clr2_ovf", overflow, 0);
    check("t5_clr2_cnt", drop_count, 0);
    drain("t5");

    // 6: capture_en low still tracks changes.
    capture_en = 1'b0;
    step(3, 0);
    step(4, 0);
    capture_en = 1'b1;
    step(4, 0);
    step(4, 0);
    check("t6_level", level, 0);
    check("t6_valid", out_valid, 0);
    step(6, 1);
    drain("t6");

    // 7: reset mid-operation discards contents and re-arms first capture.
    out_ready = 1'b0;
    step(50, 0); step(51, 0); step(52, 0);
    check("t7_level_pre", level, 3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t7_level", level, 0);
    check("t7_valid", out_valid, 0);
    check("t7_out_data", out_data, 0);
    step(52, 1);
    check("t7_first_level", level, 1);
    drain("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
